des_region_scheduler: RTL and testbench
=======================================

DES_REGION_SCHEDULER -- requirements
Module: des_region_scheduler

Interface
REQ-001 SHALL have parameter NUM_WORKERS, default 4, meaning the number of attached DES worker wrappers (2..8).
REQ-002 SHALL have parameter REGION_W, default 16, meaning the region index width.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle pulse that launches a job.
REQ-006 region_first  in  REGION_W  first region of the job; sampled on start.
REQ-007 region_last  in  REGION_W  last region of the job, inclusive; sampled on start.
REQ-008 abort  in  1  level; cancels the running job.
REQ-009 busy  out  1  job in progress (DISPATCH, DRAIN or ABORT).
REQ-010 all_done  out  1  one-cycle pulse when every region of the job has been reported.
REQ-011 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-012 res_region / res_counter  out  REGION_W / 64  result region index and that worker's counter.
REQ-013 wk_cmd  out  NUM_WORKERS*4  per-worker command.
REQ-014 wk_cmd_valid  out  NUM_WORKERS  per-worker command valid.
REQ-015 wk_region  out  NUM_WORKERS*REGION_W  per-worker region value.
REQ-016 wk_cmd_read / wk_done  in  NUM_WORKERS each  worker command-accepted / worker finished.
REQ-017 wk_counter  in  NUM_WORKERS*64  per-worker counter, valid while wk_done=1.

Function
REQ-018 Command codes SHALL be: READ_REGION=4'h0, START=4'h1, RESTART=4'h3.
REQ-019 Each worker FSM SHALL cycle W_IDLE -> W_LOAD -> W_START -> W_RUN -> W_REPORT -> W_RESTART -> W_IDLE.
REQ-020 In W_LOAD, W_START and W_RESTART the FSM SHALL hold wk_cmd_valid=1 with READ_REGION, START or RESTART respectively until wk_cmd_read=1, then advance on the next edge.
REQ-021 wk_region SHALL hold the assigned region from W_LOAD through W_REPORT.
REQ-022 W_RUN SHALL advance to W_REPORT when wk_done=1; W_REPORT SHALL hold until its result is granted.
REQ-023 Top FSM states SHALL be IDLE, DISPATCH, DRAIN, ABORT.
REQ-024 IDLE + start SHALL latch region_first into a REGION_W+1-bit next_region and region_last, then enter DISPATCH.
REQ-025 DISPATCH SHALL assign at most one region per cycle to the lowest-index idle worker at or after the rotating pointer, then increment next_region and move the pointer past that worker.
REQ-026 The 17-bit next_region SHALL NOT wrap; region_last=0xFFFF therefore dispatches 0xFFFF exactly once.
REQ-027 DISPATCH SHALL enter DRAIN once next_region > region_last; if region_first > region_last, it SHALL enter DRAIN with zero regions dispatched.
REQ-028 DRAIN SHALL enter IDLE and pulse all_done for one cycle when all workers are in W_IDLE and res_valid=0.
REQ-029 The result arbiter SHALL round-robin among workers in W_REPORT and load one result into the output register whenever the register is empty or is emptying in the same cycle (res_valid & res_ready).
REQ-030 res_valid, res_region and res_counter SHALL stay stable until res_ready=1; back-to-back results SHALL sustain 1 result per cycle.
REQ-031 start SHALL be ignored while busy=1.
REQ-032 abort in DISPATCH or DRAIN SHALL enter ABORT: dispatch stops, results in W_REPORT are discarded and those workers restarted, res_valid is cleared, and workers in W_LOAD or W_START complete their handshake and are then restarted.
REQ-033 ABORT SHALL return to IDLE without all_done once all workers are in W_IDLE.
REQ-034 abort in IDLE SHALL have no effect.

Reset
REQ-035 On rst_n=0 the block SHALL set the top FSM to IDLE, all worker FSMs to W_IDLE, and the pointers to 0.
REQ-036 On rst_n=0 the block SHALL drive busy, all_done, res_valid and wk_cmd_valid to 0, and res_region, res_counter and wk_region to 0.
REQ-037 Reset mid-job SHALL drop all state with no all_done; the workers are reset by the same rst_n.

Structure
REQ-038 Package des_sched_pkg SHALL hold the command codes, the top and worker state encodings, and the default NUM_WORKERS and REGION_W.
REQ-039 The per-worker FSM SHALL be sub-module des_sched_worker_fsm, instantiated NUM_WORKERS times.

Verification
REQ-040 Job 0x0010..0x0013 with 4 workers answering cmd_read after 1 cycle and done after 5 cycles, res_ready=1 -> regions 0x10, 0x11, 0x12, 0x13 reported exactly once, then a single all_done pulse.
REQ-041 Job 0x0005..0x0004 -> no wk_cmd_valid is asserted; all_done pulses within 3 cycles.
REQ-042 Job 0xFFFE..0xFFFF -> exactly 2 results (0xFFFE, 0xFFFF); no region 0x0000 is dispatched.
REQ-043 Job of 10 regions with res_ready low for 20 cycles -> res_valid and its data held stable; no result lost or duplicated; all_done follows the 10th handshake.
REQ-044 abort 3 cycles after start of a 100-region job -> every worker receives RESTART; busy falls; no all_done; a following job 0..1 completes normally.
REQ-045 A second start while busy and rst_n low mid-job -> the second start is ignored; after reset all outputs are 0 and the FSMs are idle.

Source files
------------

// File: rtl/des_sched_pkg.sv
// Shared command codes, FSM encodings and default sizing for the DES region scheduler.
// Pure declarations plus a combinational round-robin pick helper; no state.
// No flow control of its own.
package des_sched_pkg;

    localparam int DEF_NUM_WORKERS = 4;
    localparam int DEF_REGION_W    = 16;

    localparam logic [3:0] CMD_READ_REGION = 4'h0;
    localparam logic [3:0] CMD_START       = 4'h1;
    localparam logic [3:0] CMD_RESTART     = 4'h3;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DISPATCH = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [1:0] S_ABORT    = 2'd3;

    localparam logic [2:0] W_IDLE    = 3'd0;
    localparam logic [2:0] W_LOAD    = 3'd1;
    localparam logic [2:0] W_START   = 3'd2;
    localparam logic [2:0] W_RUN     = 3'd3;
    localparam logic [2:0] W_REPORT  = 3'd4;
    localparam logic [2:0] W_RESTART = 3'd5;

    // First requester at or after ptr, wrapping modulo n (n <= 8).
    function automatic void rr_pick(input logic [7:0] req, input int ptr, input int n,
                                    output logic found, output int idx);
        found = 1'b0;
        idx   = 0;
        for (int k = 7; k >= 0; k--) begin
            int cand;
            cand = ptr + k;
            if (cand >= n) cand = cand - n;
            if (k < n && req[cand[2:0]]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    endfunction

endpackage

// File: rtl/des_sched_worker_fsm.sv
// Per-worker sequencer: load region, start, wait for done, report, restart.
// Each command step takes one cycle after the wrapper's cmd_read; report waits for grant.
// Holds cmd_valid until cmd_read; abort_req diverts to RESTART once any open handshake completes.
module des_sched_worker_fsm
    import des_sched_pkg::*;
#(
    parameter int REGION_W = DEF_REGION_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                assign_vld,
    input  logic [REGION_W-1:0] assign_region,
    input  logic                abort_req,
    input  logic                grant,
    input  logic                cmd_read,
    input  logic                done,
    output logic [3:0]          cmd,
    output logic                cmd_valid,
    output logic [REGION_W-1:0] region,
    output logic [2:0]          state
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= W_IDLE;
            region <= '0;
        end else begin
            case (state)
                W_IDLE: begin
                    if (assign_vld) begin
                        region <= assign_region;
                        state  <= W_LOAD;
                    end
                end
                W_LOAD:    if (cmd_read) state <= abort_req ? W_RESTART : W_START;
                W_START:   if (cmd_read) state <= abort_req ? W_RESTART : W_RUN;
                W_RUN: begin
                    if (abort_req)  state <= W_RESTART;
                    else if (done)  state <= W_REPORT;
                end
                // An aborted report is simply dropped; the wrapper is still restarted.
                W_REPORT:  if (abort_req || grant) state <= W_RESTART;
                W_RESTART: if (cmd_read) state <= W_IDLE;
                default:   state <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd       = CMD_READ_REGION;
        cmd_valid = 1'b0;
        case (state)
            W_LOAD:    cmd_valid = 1'b1;
            W_START: begin
                cmd       = CMD_START;
                cmd_valid = 1'b1;
            end
            W_RESTART: begin
                cmd       = CMD_RESTART;
                cmd_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/des_region_scheduler.sv
// Spreads an inclusive region range over NUM_WORKERS DES wrappers and collects their counters.
// One region dispatched per cycle; results leave via a one-deep register, 1/cycle sustained.
// res_valid/res_ready holds data stable; a stalled output stalls reporting workers, then dispatch.
module des_region_scheduler
    import des_sched_pkg::*;
#(
    parameter int NUM_WORKERS = DEF_NUM_WORKERS,
    parameter int REGION_W    = DEF_REGION_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [REGION_W-1:0]             region_first,
    input  logic [REGION_W-1:0]             region_last,
    input  logic                            abort,
    output logic                            busy,
    output logic                            all_done,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [REGION_W-1:0]             res_region,
    output logic [63:0]                     res_counter,
    output logic [NUM_WORKERS*4-1:0]        wk_cmd,
    output logic [NUM_WORKERS-1:0]          wk_cmd_valid,
    output logic [NUM_WORKERS*REGION_W-1:0] wk_region,
    input  logic [NUM_WORKERS-1:0]          wk_cmd_read,
    input  logic [NUM_WORKERS-1:0]          wk_done,
    input  logic [NUM_WORKERS*64-1:0]       wk_counter
);

    localparam int PTR_W = $clog2(NUM_WORKERS);

    logic [1:0]             state;
    logic [REGION_W:0]      next_region;
    logic [REGION_W-1:0]    last_region;
    logic [PTR_W-1:0]       disp_ptr, arb_ptr, disp_sel, arb_sel;
    logic [2:0]             wstate [NUM_WORKERS];
    logic [NUM_WORKERS-1:0] w_idle, w_report, assign_vec, grant_vec;
    logic                   disp_found, arb_found;
    int                     disp_idx, arb_idx;
    logic                   running, abort_req, range_done, do_dispatch, do_load;

    assign busy       = (state != S_IDLE);
    assign running    = (state == S_DISPATCH) || (state == S_DRAIN);
    assign abort_req  = (state == S_ABORT);
    // The extra bit keeps next_region from wrapping past the top of the index space.
    assign range_done = (next_region > {1'b0, last_region});

    always_comb begin
        rr_pick(8'(w_idle),   int'(disp_ptr), NUM_WORKERS, disp_found, disp_idx);
        rr_pick(8'(w_report), int'(arb_ptr),  NUM_WORKERS, arb_found,  arb_idx);
    end

    assign disp_sel    = PTR_W'(disp_idx);
    assign arb_sel     = PTR_W'(arb_idx);
    assign do_dispatch = (state == S_DISPATCH) && !abort && !range_done && disp_found;
    assign do_load     = running && !abort && arb_found && (!res_valid || res_ready);

    always_comb begin
        assign_vec = '0;
        grant_vec  = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            if (do_dispatch && disp_sel == PTR_W'(i)) assign_vec[i] = 1'b1;
            if (do_load && arb_sel == PTR_W'(i))      grant_vec[i]  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            next_region <= '0;
            last_region <= '0;
            disp_ptr    <= '0;
            arb_ptr     <= '0;
            all_done    <= 1'b0;
            res_valid   <= 1'b0;
            res_region  <= '0;
            res_counter <= '0;
        end else begin
            all_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        next_region <= {1'b0, region_first};
                        last_region <= region_last;
                        state       <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (abort) begin
                        state <= S_ABORT;
                    end else if (range_done) begin
                        state <= S_DRAIN;
                    end else if (do_dispatch) begin
                        next_region <= next_region + 1'b1;
                        disp_ptr    <= (disp_sel == PTR_W'(NUM_WORKERS - 1)) ? '0 : disp_sel + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state <= S_ABORT;
                    end else if (&w_idle && !res_valid) begin
                        state    <= S_IDLE;
                        all_done <= 1'b1;
                    end
                end
                S_ABORT:  if (&w_idle) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase

            if ((running && abort) || abort_req) begin
                res_valid <= 1'b0;
            end else if (do_load) begin
                res_valid   <= 1'b1;
                res_region  <= wk_region[arb_sel*REGION_W +: REGION_W];
                res_counter <= wk_counter[arb_sel*64 +: 64];
                arb_ptr     <= (arb_sel == PTR_W'(NUM_WORKERS - 1)) ? '0 : arb_sel + 1'b1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_WORKERS; g++) begin : g_wk
        des_sched_worker_fsm #(
            .REGION_W(REGION_W)
        ) u_fsm (
            .clk          (clk),
            .rst_n        (rst_n),
            .assign_vld   (assign_vec[g]),
            .assign_region(next_region[REGION_W-1:0]),
            .abort_req    (abort_req),
            .grant        (grant_vec[g]),
            .cmd_read     (wk_cmd_read[g]),
            .done         (wk_done[g]),
            .cmd          (wk_cmd[g*4 +: 4]),
            .cmd_valid    (wk_cmd_valid[g]),
            .region       (wk_region[g*REGION_W +: REGION_W]),
            .state        (wstate[g])
        );
        assign w_idle[g]   = (wstate[g] == W_IDLE);
        assign w_report[g] = (wstate[g] == W_REPORT);
    end

endmodule

// File: tb/tb_des_region_scheduler.sv
// Directed bench for des_region_scheduler with four modelled DES wrappers
// (cmd_read one cycle after cmd_valid, done five cycles after START).
module tb_des_region_scheduler;
    import des_sched_pkg::*;

    localparam int N  = 4;
    localparam int RW = 16;

    logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, res_ready = 1'b0;
    logic [RW-1:0]   region_first = '0, region_last = '0;
    logic            busy, all_done, res_valid;
    logic [RW-1:0]   res_region;
    logic [63:0]     res_counter;
    logic [N*4-1:0]  wk_cmd;
    logic [N-1:0]    wk_cmd_valid;
    logic [N*RW-1:0] wk_region;
    logic [N-1:0]    wk_cmd_read = '0, wk_done = '0;
    logic [N*64-1:0] wk_counter = '0;

    always #5 clk = ~clk;

    des_region_scheduler #(.NUM_WORKERS(N), .REGION_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .region_first(region_first),
        .region_last(region_last), .abort(abort), .busy(busy), .all_done(all_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_region(res_region),
        .res_counter(res_counter), .wk_cmd(wk_cmd), .wk_cmd_valid(wk_cmd_valid),
        .wk_region(wk_region), .wk_cmd_read(wk_cmd_read), .wk_done(wk_done),
        .wk_counter(wk_counter)
    );

    int checks = 0, errors = 0;

    logic [3:0]    cap [N];
    bit            pend [N];
    int            run_cnt [N];
    logic [RW-1:0] mreg [N];
    int            load_cnt [N], restart_cnt [N];
    logic [RW-1:0] res_log [$];
    int            all_done_cnt, done_log_size, cmd_valid_seen, bad_cnt, zero_disp, disp_cnt;

    function automatic logic [63:0] exp_counter(input logic [RW-1:0] r);
        return {32'hDE5C_0000, 16'h0000, r};
    endfunction

    function automatic int count_region(input logic [RW-1:0] r);
        int c = 0;
        foreach (res_log[k]) if (res_log[k] == r) c++;
        return c;
    endfunction

    // Wrapper model and result monitor, both away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            wk_cmd_read = '0;
            wk_done     = '0;
            wk_counter  = '0;
            for (int i = 0; i < N; i++) begin
                cap[i] = CMD_READ_REGION; pend[i] = 0; run_cnt[i] = 0; mreg[i] = '0;
            end
        end else begin
            if (all_done) begin
                all_done_cnt++;
                done_log_size = res_log.size();
            end
            if (|wk_cmd_valid) cmd_valid_seen++;
            if (res_valid && res_ready) begin
                res_log.push_back(res_region);
                if (res_counter !== exp_counter(res_region)) bad_cnt++;
            end
            for (int i = 0; i < N; i++) begin
                if (wk_cmd_read[i]) begin
                    wk_cmd_read[i] = 1'b0;
                    pend[i] = 0;
                    case (cap[i])
                        CMD_READ_REGION: begin
                            mreg[i] = wk_region[i*RW +: RW];
                            load_cnt[i]++;
                            disp_cnt++;
                            if (mreg[i] == '0) zero_disp++;
                        end
                        CMD_START:   run_cnt[i] = 5;
                        CMD_RESTART: begin
                            restart_cnt[i]++;
                            run_cnt[i] = 0;
                            wk_done[i] = 1'b0;
                        end
                        default: ;
                    endcase
                end else if (wk_cmd_valid[i]) begin
                    if (pend[i]) begin
                        wk_cmd_read[i] = 1'b1;
                        cap[i] = wk_cmd[i*4 +: 4];
                    end else begin
                        pend[i] = 1;
                    end
                end
                if (run_cnt[i] > 0) begin
                    run_cnt[i]--;
                    if (run_cnt[i] == 0) wk_done[i] = 1'b1;
                end
                wk_counter[i*64 +: 64] = wk_done[i] ? exp_counter(mreg[i]) : 64'h0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        res_log.delete();
        all_done_cnt = 0; done_log_size = -1; cmd_valid_seen = 0;
        bad_cnt = 0; zero_disp = 0; disp_cnt = 0;
        for (int i = 0; i < N; i++) begin load_cnt[i] = 0; restart_cnt[i] = 0; end
    endtask

    task automatic run_job(input logic [RW-1:0] first, input logic [RW-1:0] last);
        region_first = first;
        region_last  = last;
        start = 1'b1;
        cycle(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int took);
        took = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (all_done) begin took = k; break; end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int took, unstable, tot_load, fell;
        logic [RW-1:0] r0;
        logic [63:0]   c0;

        clear_logs();
        cycle(3);
        chk("reset_busy",      busy,         1'b0);
        chk("reset_all_done",  all_done,     1'b0);
        chk("reset_res_valid", res_valid,    1'b0);
        chk("reset_cmd_valid", wk_cmd_valid, '0);
        chk("reset_res_data",  {res_region, res_counter}, '0);
        chk("reset_wk_region", wk_region,    '0);
        rst_n = 1'b1;
        cycle(2);

        // Four regions over four workers
        clear_logs();
        res_ready = 1'b1;
        run_job(16'h0010, 16'h0013);
        chk("j1_busy", busy, 1'b1);
        wait_done(300, took);
        chk("j1_done_seen", took > 0, 1'b1);
        cycle(5);
        chk("j1_count", res_log.size(), 4);
        for (int r = 16'h10; r <= 16'h13; r++) chk("j1_once", count_region(RW'(r)), 1);
        chk("j1_counter_pairing", bad_cnt, 0);
        chk("j1_all_done_pulses", all_done_cnt, 1);
        chk("j1_idle", busy, 1'b0);

        // Empty range
        clear_logs();
        run_job(16'h0005, 16'h0004);
        wait_done(20, took);
        chk("empty_done_within_3", took >= 1 && took <= 3, 1'b1);
        chk("empty_no_cmd_valid", cmd_valid_seen, 0);
        chk("empty_no_results", res_log.size(), 0);

        // Top of the index space must not wrap to 0
        clear_logs();
        run_job(16'hFFFE, 16'hFFFF);
        wait_done(300, took);
        chk("top_done_seen", took > 0, 1'b1);
        cycle(3);
        chk("top_count", res_log.size(), 2);
        chk("top_fffe", count_region(16'hFFFE), 1);
        chk("top_ffff", count_region(16'hFFFF), 1);
        chk("top_dispatches", disp_cnt, 2);
        chk("top_no_zero_dispatch", zero_disp, 0);

        // Output stalled for 20 cycles
        clear_logs();
        res_ready = 1'b0;
        run_job(16'h0100, 16'h0109);
        fell = 0;
        for (int k = 0; k < 100 && !res_valid; k++) @(negedge clk);
        chk("stall_valid_seen", res_valid, 1'b1);
        r0 = res_region;
        c0 = res_counter;
        chk("stall_counter_pairing", c0, exp_counter(r0));
        unstable = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_region !== r0 || res_counter !== c0) unstable++;
        end
        chk("stall_stable", unstable, 0);
        chk("stall_not_done", all_done_cnt, 0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_done(400, took);
        chk("stall_done_seen", took > 0, 1'b1);
        cycle(3);
        chk("stall_count", res_log.size(), 10);
        for (int r = 16'h100; r <= 16'h109; r++) chk("stall_once", count_region(RW'(r)), 1);
        chk("stall_counter_pairing_all", bad_cnt, 0);
        chk("stall_done_after_10th", done_log_size, 10);
        chk("stall_all_done_pulses", all_done_cnt, 1);

        // Abort early in a long job: two regions were handed out before abort landed
        clear_logs();
        run_job(16'h0000, 16'd99);
        cycle(2);
        abort = 1'b1;
        fell = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin fell = 1; break; end
        end
        chk("abort_busy_fell", fell, 1);
        @(posedge clk); #1;
        abort = 1'b0;
        tot_load = 0;
        for (int i = 0; i < N; i++) begin
            tot_load += load_cnt[i];
            chk("abort_restart_each", restart_cnt[i], load_cnt[i]);
        end
        chk("abort_dispatched", tot_load, 2);
        chk("abort_no_all_done", all_done_cnt, 0);
        chk("abort_no_results", res_log.size(), 0);
        chk("abort_res_valid", res_valid, 1'b0);

        abort = 1'b1;
        cycle(3);
        chk("abort_idle_no_effect", busy, 1'b0);
        abort = 1'b0;

        clear_logs();
        run_job(16'h0000, 16'h0001);
        wait_done(300, took);
        chk("post_abort_done_seen", took > 0, 1'b1);
        cycle(3);
        chk("post_abort_count", res_log.size(), 2);
        chk("post_abort_r0", count_region(16'h0000), 1);
        chk("post_abort_r1", count_region(16'h0001), 1);

        // Second start while busy is ignored
        clear_logs();
        run_job(16'h0020, 16'h0023);
        cycle(1);
        run_job(16'h0500, 16'h0500);
        wait_done(300, took);
        chk("restart_ign_done_seen", took > 0, 1'b1);
        cycle(3);
        chk("restart_ign_count", res_log.size(), 4);
        chk("restart_ign_no_0500", count_region(16'h0500), 0);
        chk("restart_ign_pulses", all_done_cnt, 1);

        // Reset mid-job
        clear_logs();
        run_job(16'h0040, 16'h007F);
        cycle(8);
        chk("midjob_busy", busy, 1'b1);
        rst_n = 1'b0;
        cycle(2);
        chk("midrst_busy",      busy,         1'b0);
        chk("midrst_all_done",  all_done,     1'b0);
        chk("midrst_res_valid", res_valid,    1'b0);
        chk("midrst_cmd_valid", wk_cmd_valid, '0);
        chk("midrst_res_data",  {res_region, res_counter}, '0);
        chk("midrst_wk_region", wk_region,    '0);
        rst_n = 1'b1;
        cycle(5);
        chk("postrst_busy",      busy,         1'b0);
        chk("postrst_cmd_valid", wk_cmd_valid, '0);
        chk("postrst_no_done",   all_done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
